padded_window_reader: RTL and testbench

// - Reader side of the zero-padded feature-map SRAM that the padding controller writes.
// - Scans the unpadded output grid row-major (IMG_H x IMG_W) and fetches each 3x3 window from the padded map (pitch PW=IMG_W+2).
// - Delivers each window as one 9-tap word to the conv datapath over a valid/ready handshake.

---
 rtl/padded_window_reader_pkg.sv | 19 +
 rtl/padded_window_reader_addr_gen.sv | 112 +++++++++++
 rtl/padded_window_reader.sv | 102 ++++++++++
 tb/tb_padded_window_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/padded_window_reader_pkg.sv
// Shared types and constants for the padded-map 3x3 window reader.
package padded_window_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_e;

    localparam int TAPS  = 9;
    localparam int TAP_W = 4;

    // Padded pitch: one zero column on each side of the image.
    function automatic int calc_pw(input int img_w);
        return img_w + 2;
    endfunction

endpackage

// File: rtl/padded_window_reader_addr_gen.sv
// Window position counters and incremental SRAM address walk over the 3x3 taps.
module padded_addr_gen
    import padded_window_reader_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 180,
    parameter int ADDR_W = 16,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              issue,
    input  logic              advance,
    output logic [ADDR_W-1:0] sram_addr_b,
    output logic [TAP_W-1:0]  tap,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col,
    output logic              win_last
);

    localparam logic [ADDR_W-1:0] PW_A   = ADDR_W'(calc_pw(IMG_W));
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [15:0]       LAST_R = 16'(IMG_H - 1);
    localparam logic [15:0]       LAST_C = 16'(IMG_W - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAPS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [1:0]        col_off_q, col_off_d;
    logic [15:0]       r_q, r_d;
    logic [15:0]       c_q, c_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            row_base_q <= BASE_A;
            win_base_q <= BASE_A;
            tap_q      <= '0;
            col_off_q  <= '0;
            r_q        <= '0;
            c_q        <= '0;
        end else begin
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            win_base_q <= win_base_d;
            tap_q      <= tap_d;
            col_off_q  <= col_off_d;
            r_q        <= r_d;
            c_q        <= c_d;
        end
    end

    always_comb begin
        addr_d     = addr_q;
        row_base_d = row_base_q;
        win_base_d = win_base_q;
        tap_d      = tap_q;
        col_off_d  = col_off_q;
        r_d        = r_q;
        c_d        = c_q;
        if (load) begin
            addr_d     = BASE_A;
            row_base_d = BASE_A;
            win_base_d = BASE_A;
            tap_d      = '0;
            col_off_d  = '0;
            r_d        = '0;
            c_d        = '0;
        end else if (advance) begin
            tap_d     = '0;
            col_off_d = '0;
            if (win_last) begin
                r_d        = '0;
                c_d        = '0;
                win_base_d = BASE_A;
            end else if (c_q == LAST_C) begin
                // Last column to next row start skips the two pad columns: +3.
                c_d        = '0;
                r_d        = r_q + 16'd1;
                win_base_d = win_base_q + ADDR_W'(3);
            end else begin
                c_d        = c_q + 16'd1;
                win_base_d = win_base_q + ADDR_W'(1);
            end
            row_base_d = win_base_d;
            addr_d     = win_base_d;
        end else if (issue) begin
            tap_d = tap_q + 4'd1;
            // Address stays on tap 8 after the final issue so it is stable while presenting.
            if (tap_q != TAP_LAST) begin
                if (col_off_q == 2'd2) begin
                    col_off_d  = '0;
                    row_base_d = row_base_q + PW_A;
                    addr_d     = row_base_q + PW_A;
                end else begin
                    col_off_d = col_off_q + 2'd1;
                    addr_d    = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign sram_addr_b = addr_q;
    assign tap         = tap_q;
    assign win_row     = r_q;
    assign win_col     = c_q;
    assign win_last    = (r_q == LAST_R) && (c_q == LAST_C);

endmodule

// File: rtl/padded_window_reader.sv
// Scans the output grid, fetches each 3x3 window from the padded SRAM and hands it out over valid/ready.
module padded_window_reader
    import padded_window_reader_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 180,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int BASE   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [ADDR_W-1:0]      sram_addr_b,
    output logic                   sram_ren_b,
    input  logic [DATA_W-1:0]      sram_rdata,
    output logic [TAPS*DATA_W-1:0] win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [15:0]            win_row,
    output logic [15:0]            win_col,
    output logic                   win_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [TAP_W-1:0] TAP_END = TAP_W'(TAPS);

    state_e state_q, state_d;
    logic [TAPS*DATA_W-1:0] taps_q, taps_d;
    logic                   cap_pend_q, cap_pend_d;
    logic [TAP_W-1:0]       cap_idx_q, cap_idx_d;
    logic [TAP_W-1:0]       tap;
    logic                   load, issue, accept;

    padded_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .BASE  (BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .issue      (issue),
        .advance    (accept),
        .sram_addr_b(sram_addr_b),
        .tap        (tap),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (cap_pend_q && cap_idx_q == TAP_W'(TAPS - 1)) state_d = PRESENT;
            PRESENT: if (win_ready) state_d = win_last ? FINISH : FETCH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load       = (state_q == IDLE) && start;
        issue      = (state_q == FETCH) && (tap != TAP_END);
        accept     = (state_q == PRESENT) && win_ready;
        sram_ren_b = !issue;
        win_valid  = (state_q == PRESENT);
        busy       = (state_q != IDLE);
        done       = (state_q == FINISH);
    end

    // Read data lags its address by one cycle, so the slot index rides along in cap_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_q     <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
        end else begin
            taps_q     <= taps_d;
            cap_pend_q <= cap_pend_d;
            cap_idx_q  <= cap_idx_d;
        end
    end

    always_comb begin
        taps_d     = taps_q;
        cap_pend_d = issue;
        cap_idx_d  = tap;
        if (cap_pend_q) taps_d[int'(cap_idx_q)*DATA_W +: DATA_W] = sram_rdata;
    end

    assign win_data = taps_q;

endmodule

// File: tb/tb_padded_window_reader.sv
// Scoreboard bench: expected addresses and windows queued by the driver, popped by a negedge monitor.
module tb_padded_window_reader;

    localparam int W0 = 320, H0 = 180, B0 = 0;
    localparam int W1 = 4,   H1 = 3,   B1 = 16;

    typedef struct packed {
        logic [71:0] data;
        logic [15:0] row;
        logic [15:0] col;
        logic        last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, ready = 1'b0;
    logic [15:0] addr0, addr1, row0, row1, col0, col1;
    logic [7:0]  rd0 = '0, rd1 = '0;
    logic [71:0] wd0, wd1;
    logic ren0, ren1, v0, v1, l0, l1, b0, b1, d0, d1;

    int checks = 0, errors = 0, win_seen = 0;
    int exp_addr[$];
    win_t exp_win[$];
    win_t mon_ew;

    always #5 clk = ~clk;

    padded_window_reader dut (
        .clk(clk), .rst(rst), .start(start0),
        .sram_addr_b(addr0), .sram_ren_b(ren0), .sram_rdata(rd0),
        .win_data(wd0), .win_valid(v0), .win_ready(ready),
        .win_row(row0), .win_col(col0), .win_last(l0), .busy(b0), .done(d0)
    );

    padded_window_reader #(.IMG_W(W1), .IMG_H(H1), .BASE(B1)) dut_s (
        .clk(clk), .rst(rst), .start(start1),
        .sram_addr_b(addr1), .sram_ren_b(ren1), .sram_rdata(rd1),
        .win_data(wd1), .win_valid(v1), .win_ready(ready),
        .win_row(row1), .win_col(col1), .win_last(l1), .busy(b1), .done(d1)
    );

    // SRAM holding addr-as-data, one-cycle read latency.
    always @(posedge clk) begin
        if (!ren0) rd0 <= addr0[7:0];
        if (!ren1) rd1 <= addr1[7:0];
    end

    logic [15:0] m_addr, m_row, m_col;
    logic [71:0] m_wd;
    logic m_ren, m_valid, m_last, m_busy, m_done;
    assign m_addr  = sel ? addr1 : addr0;
    assign m_row   = sel ? row1  : row0;
    assign m_col   = sel ? col1  : col0;
    assign m_wd    = sel ? wd1   : wd0;
    assign m_ren   = sel ? ren1  : ren0;
    assign m_valid = sel ? v1    : v0;
    assign m_last  = sel ? l1    : l0;
    assign m_busy  = sel ? b1    : b0;
    assign m_done  = sel ? d1    : d0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_win(input int w, input int h, input int b, input int r, input int c,
                            input bit addr_only);
        logic [71:0] d;
        int a;
        win_t e;
        d = '0;
        for (int k = 0; k < 9; k++) begin
            a = b + (r + k / 3) * (w + 2) + c + k % 3;
            exp_addr.push_back(a);
            d[k*8 +: 8] = a[7:0];
        end
        e.data = d;
        e.row  = r[15:0];
        e.col  = c[15:0];
        e.last = (r == h - 1) && (c == w - 1);
        if (!addr_only) exp_win.push_back(e);
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_win.delete();
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_addr"},  72'(m_addr),  72'(0));
        chk({tag, "_ren"},   72'(m_ren),   72'(1));
        chk({tag, "_data"},  m_wd,         72'(0));
        chk({tag, "_valid"}, 72'(m_valid), 72'(0));
        chk({tag, "_row"},   72'(m_row),   72'(0));
        chk({tag, "_col"},   72'(m_col),   72'(0));
        chk({tag, "_last"},  72'(m_last),  72'(0));
        chk({tag, "_busy"},  72'(m_busy),  72'(0));
        chk({tag, "_done"},  72'(m_done),  72'(0));
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        flush();
        @(posedge clk); #1;
        rst_vals(tag);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk(name, 72'(m_valid), 72'(1));
    endtask

    task automatic wait_seen(input int target, input int bound);
        int n = 0;
        while (win_seen < target && n < bound) begin @(posedge clk); #1; n++; end
        chk("win_count", 72'(win_seen), 72'(target));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!m_ren) begin
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL addr: unexpected read of %0d, none expected", m_addr);
                end else chk("addr", 72'(m_addr), 72'(exp_addr.pop_front()));
            end
            if (m_valid && ready) begin
                if (exp_win.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL win: unexpected accept r=%0d c=%0d, none expected", m_row, m_col);
                end else begin
                    mon_ew = exp_win.pop_front();
                    chk("win_data", m_wd, mon_ew.data);
                    chk("win_row",  72'(m_row),  72'(mon_ew.row));
                    chk("win_col",  72'(m_col),  72'(mon_ew.col));
                    chk("win_last", 72'(m_last), 72'(mon_ew.last));
                end
                win_seen++;
            end
        end
    end

    initial begin
        int first_addrs[9] = '{0, 1, 2, 322, 323, 324, 644, 645, 646};
        logic [71:0] hold_d, tmp;
        logic [15:0] hold_a;
        int base, dcnt, after;
        bit seen_last;

        // Full-size map: first window latency, hold, and row wrap.
        sel = 1'b0;
        reset_dut("rst0");
        for (int w = 0; w <= 322; w++) push_win(W0, H0, B0, w / W0, w % W0, w == 322);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("busy_after_start", 72'(m_busy), 72'(1));
        for (int k = 0; k < 9; k++) begin
            chk("first_addr", 72'(m_addr), 72'(first_addrs[k]));
            chk("first_ren", 72'(m_ren), 72'(0));
            @(posedge clk); #1;
        end
        chk("valid_before_e10", 72'(m_valid), 72'(0));
        @(posedge clk); #1;
        chk("valid_at_e10", 72'(m_valid), 72'(1));
        chk("first_row", 72'(m_row), 72'(0));
        chk("first_col", 72'(m_col), 72'(0));
        hold_d = m_wd;
        hold_a = m_addr;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_data", m_wd, hold_d);
            chk("hold_ren", 72'(m_ren), 72'(1));
            chk("hold_addr", 72'(m_addr), 72'(hold_a));
            chk("hold_valid", 72'(m_valid), 72'(1));
        end
        ready = 1'b1;
        wait_seen(322, 5000);
        ready = 1'b0;
        wait_valid("valid_w322");
        chk("w322_row", 72'(m_row), 72'(1));
        chk("w322_col", 72'(m_col), 72'(2));

        // Reset in the middle of a fetch, then restart.
        reset_dut("rst1");
        push_win(W0, H0, B0, 0, 0, 1);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("tap4_addr", 72'(m_addr), 72'(323));
        rst = 1'b1;
        flush();
        #1;
        rst_vals("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        push_win(W0, H0, B0, 0, 0, 0);
        push_win(W0, H0, B0, 0, 1, 1);
        base = win_seen;
        start0 = 1'b1;
        @(posedge clk); #1;
        chk("restart_addr", 72'(m_addr), 72'(0));
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_valid("valid_restart");
        ready = 1'b1;
        wait_seen(base + 1, 40);
        ready = 1'b0;
        wait_valid("valid_w1");
        chk("w1_col", 72'(m_col), 72'(1));

        // Small map with BASE offset: full frame, last window, done pulse.
        sel = 1'b1;
        reset_dut("rst2");
        for (int w = 0; w < W1 * H1; w++) push_win(W1, H1, B1, w / W1, w % W1, 0);
        base = win_seen;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        dcnt = 0;
        after = -1;
        seen_last = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            ready = (i % 3) != 2;
            if (i == 5) start1 = 1'b1;
            if (m_valid && m_row == 16'd2 && m_col == 16'd3 && !seen_last) begin
                seen_last = 1'b1;
                tmp = m_wd;
                chk("last_tap0", 72'(tmp[7:0]), 72'(31));
                chk("last_tap8", 72'(tmp[71:64]), 72'(45));
                chk("last_flag", 72'(m_last), 72'(1));
            end
            if (m_done) begin
                dcnt++;
                start1 = 1'b1;
                after = i;
            end
            if (after >= 0 && i == after + 1) chk("busy_after_done", 72'(m_busy), 72'(0));
            if (after >= 0 && i == after + 20) break;
        end
        ready = 1'b0;
        start1 = 1'b0;
        chk("done_pulses", 72'(dcnt), 72'(1));
        chk("small_windows", 72'(win_seen - base), 72'(W1 * H1));
        chk("win_q_empty", 72'(exp_win.size()), 72'(0));
        chk("addr_q_empty", 72'(exp_addr.size()), 72'(0));
        chk("busy_end", 72'(m_busy), 72'(0));
        chk("row_cleared", 72'(m_row), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
